// File: rtl/sqrt_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sqrt_pkg                                                           |
// | Shared types and sizing helper for the square-root datapath.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sqrt_state_e;

    // Root width for a given radicand width and fractional-bit count.
    function automatic int sqrt_qw(input int width, input int frac);
        return width / 2 + frac;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sqrt_step.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sqrt_step                                                          |
// | One restoring digit-by-digit square-root iteration (combinational).|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sqrt_step #(
    parameter int RW = 7
) (
    input  logic [RW-1:0] i_rem,
    input  logic [RW-2:0] i_root,
    input  logic [1:0]    i_bits,
    output logic [RW-1:0] o_rem,
    output logic [RW-2:0] o_root
);

    localparam int QW = RW - 1;

    logic [RW:0] w_trial;
    logic [RW:0] w_test;
    logic [RW:0] w_diff;
    logic        w_ge;

    // The remainder is bounded by 2*root, so its top bit is always clear
    // on entry and dropping it keeps the trial within RW+1 bits.
    assign w_trial = (RW+1)'({i_rem, i_bits});
    assign w_test  = {i_root, 2'b01};
    assign w_ge    = (w_trial >= w_test);
    assign w_diff  = w_trial - w_test;

    assign o_rem  = w_ge ? RW'(w_diff) : RW'(w_trial);
    assign o_root = QW'({i_root, w_ge});

endmodule
`default_nettype wire

// File: rtl/sqrt_seq_param.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sqrt_seq_param                                                     |
// | Multi-cycle integer/fixed-point square root, one root bit per clk. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sqrt_seq_param
    import sqrt_pkg::*;
#(
    parameter  int WIDTH     = 12,
    parameter  int FRAC_BITS = 0,
    localparam int QW        = sqrt_qw(WIDTH, FRAC_BITS),
    localparam int RW        = QW + 1
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          start,
    input  logic [WIDTH-1:0] A,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic [QW-1:0] Q,
    output logic [RW-1:0] R
);

    localparam int N  = 2 * QW;
    localparam int CW = (QW > 1) ? $clog2(QW) : 1;

    generate
        if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_width_check
            $error("sqrt_seq_param: WIDTH must be even and at least 2");
        end
    endgenerate

    sqrt_state_e   r_state;
    sqrt_state_e   w_state_nxt;
    logic [N-1:0]  r_shift;
    logic [RW-1:0] r_rem;
    logic [QW-1:0] r_root;
    logic [CW-1:0] r_cnt;
    logic [QW-1:0] r_q;
    logic [RW-1:0] r_r;
    logic [RW-1:0] w_rem_nxt;
    logic [QW-1:0] w_root_nxt;

    sqrt_step #(
        .RW (RW)
    ) u_step (
        .i_rem  (r_rem),
        .i_root (r_root),
        .i_bits (r_shift[N-1 -: 2]),
        .o_rem  (w_rem_nxt),
        .o_root (w_root_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_shift <= '0;
            r_rem   <= '0;
            r_root  <= '0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_r     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shift <= N'(A) << (2 * FRAC_BITS);
                        r_rem   <= '0;
                        r_root  <= '0;
                        r_cnt   <= CW'(QW - 1);
                    end
                end
                CALC: begin
                    r_rem   <= w_rem_nxt;
                    r_root  <= w_root_nxt;
                    r_shift <= r_shift << 2;
                    // Results are captured on entry to DONE so they are
                    // already visible while done is high.
                    if (r_cnt == '0) begin
                        r_q <= w_root_nxt;
                        r_r <= w_rem_nxt;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign Q = r_q;
    assign R = r_r;

endmodule
`default_nettype wire

// File: tb/tb_sqrt_seq_param.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sqrt_seq_param                                                  |
// | Directed and swept self-checking bench for sqrt_seq_param.         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_sqrt_seq_param;

    localparam int N_SWEEP = 1000;

    logic clk = 1'b0;
    logic rst_;
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clk = ~clk;

    // W12 F0 main instance
    logic        start;
    logic [11:0] a;
    logic        ready, busy, done;
    logic [5:0]  q;
    logic [6:0]  r;

    // W12 F2
    logic        f2_start;
    logic [11:0] f2_a;
    logic        f2_ready, f2_busy, f2_done;
    logic [7:0]  f2_q;
    logic [8:0]  f2_r;

    // Sweep instances share one start line
    logic        sw_start;
    logic [3:0]  s0_a;  logic s0_ready, s0_busy, s0_done;  logic [1:0]  s0_q;  logic [2:0]  s0_r;
    logic [3:0]  s1_a;  logic s1_ready, s1_busy, s1_done;  logic [4:0]  s1_q;  logic [5:0]  s1_r;
    logic [11:0] s2_a;  logic s2_ready, s2_busy, s2_done;  logic [8:0]  s2_q;  logic [9:0]  s2_r;
    logic [15:0] s3_a;  logic s3_ready, s3_busy, s3_done;  logic [7:0]  s3_q;  logic [8:0]  s3_r;
    logic [15:0] s4_a;  logic s4_ready, s4_busy, s4_done;  logic [10:0] s4_q;  logic [11:0] s4_r;

    sqrt_seq_param #(.WIDTH(12), .FRAC_BITS(0)) u_dut (
        .clk(clk), .rst_(rst_), .start(start), .A(a),
        .ready(ready), .busy(busy), .done(done), .Q(q), .R(r));
    sqrt_seq_param #(.WIDTH(12), .FRAC_BITS(2)) u_f2 (
        .clk(clk), .rst_(rst_), .start(f2_start), .A(f2_a),
        .ready(f2_ready), .busy(f2_busy), .done(f2_done), .Q(f2_q), .R(f2_r));
    sqrt_seq_param #(.WIDTH(4), .FRAC_BITS(0)) u_s0 (
        .clk(clk), .rst_(rst_), .start(sw_start), .A(s0_a),
        .ready(s0_ready), .busy(s0_busy), .done(s0_done), .Q(s0_q), .R(s0_r));
    sqrt_seq_param #(.WIDTH(4), .FRAC_BITS(3)) u_s1 (
        .clk(clk), .rst_(rst_), .start(sw_start), .A(s1_a),
        .ready(s1_ready), .busy(s1_busy), .done(s1_done), .Q(s1_q), .R(s1_r));
    sqrt_seq_param #(.WIDTH(12), .FRAC_BITS(3)) u_s2 (
        .clk(clk), .rst_(rst_), .start(sw_start), .A(s2_a),
        .ready(s2_ready), .busy(s2_busy), .done(s2_done), .Q(s2_q), .R(s2_r));
    sqrt_seq_param #(.WIDTH(16), .FRAC_BITS(0)) u_s3 (
        .clk(clk), .rst_(rst_), .start(sw_start), .A(s3_a),
        .ready(s3_ready), .busy(s3_busy), .done(s3_done), .Q(s3_q), .R(s3_r));
    sqrt_seq_param #(.WIDTH(16), .FRAC_BITS(3)) u_s4 (
        .clk(clk), .rst_(rst_), .start(sw_start), .A(s4_a),
        .ready(s4_ready), .busy(s4_busy), .done(s4_done), .Q(s4_q), .R(s4_r));

    // Reference: smallest-step search for floor(sqrt(x)).
    function automatic longint unsigned isqrt(input longint unsigned x);
        longint unsigned v = 0;
        while ((v + 1) * (v + 1) <= x) v++;
        return v;
    endfunction

    // Pulse start on the main instance and return cycles until done (0 = timeout).
    task automatic run_op(input logic [11:0] av, output int lat, output logic busy1);
        @(negedge clk);
        a     = av;
        start = 1'b1;
        lat   = 0;
        busy1 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            a     = 12'hA5C;
            if (c == 1) busy1 = busy & ~ready;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_ = 1'b0; start = 1'b0; f2_start = 1'b0; sw_start = 1'b0;
        a = '0; f2_a = '0; s0_a = '0; s1_a = '0; s2_a = '0; s3_a = '0; s4_a = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (ready !== 1'b1) begin n_fails++; $display("FAIL reset_ready got=%b want=1", ready); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fails++; $display("FAIL reset_done got=%b want=0", done); end
        n_checks++; if (q !== 6'd0) begin n_fails++; $display("FAIL reset_q got=%0d want=0", q); end
        n_checks++; if (r !== 7'd0) begin n_fails++; $display("FAIL reset_r got=%0d want=0", r); end
        n_checks++; if (f2_ready !== 1'b1 || f2_q !== 8'd0) begin
            n_fails++; $display("FAIL reset_f2 ready=%b q=%0d want ready=1 q=0", f2_ready, f2_q);
        end
        rst_ = 1'b1;
    endtask

    task automatic test_basic();
        int lat; logic b1;
        run_op(12'd256, lat, b1);
        n_checks++; if (b1 !== 1'b1) begin n_fails++; $display("FAIL basic_busy_calc got=%b want=1", b1); end
        n_checks++; if (lat !== 7) begin n_fails++; $display("FAIL basic_latency got=%0d want=7", lat); end
        n_checks++; if (q !== 6'd16 || r !== 7'd0) begin
            n_fails++; $display("FAIL basic_256 Q=%0d R=%0d want Q=16 R=0", q, r);
        end
        n_checks++; if (busy !== 1'b0 || ready !== 1'b0) begin
            n_fails++; $display("FAIL basic_done_flags busy=%b ready=%b want 0 0", busy, ready);
        end
        @(negedge clk);
        n_checks++; if (ready !== 1'b1 || done !== 1'b0) begin
            n_fails++; $display("FAIL basic_ready_after ready=%b done=%b want 1 0", ready, done);
        end
    endtask

    task automatic test_values();
        int lat; logic b1;
        run_op(12'd1680, lat, b1);
        n_checks++; if (q !== 6'd40 || r !== 7'd80) begin
            n_fails++; $display("FAIL val_1680 Q=%0d R=%0d want Q=40 R=80", q, r);
        end
        run_op(12'd0, lat, b1);
        n_checks++; if (lat !== 7) begin n_fails++; $display("FAIL val_zero_latency got=%0d want=7", lat); end
        n_checks++; if (q !== 6'd0 || r !== 7'd0) begin
            n_fails++; $display("FAIL val_0 Q=%0d R=%0d want Q=0 R=0", q, r);
        end
        run_op(12'd4095, lat, b1);
        n_checks++; if (q !== 6'd63 || r !== 7'd126) begin
            n_fails++; $display("FAIL val_4095 Q=%0d R=%0d want Q=63 R=126", q, r);
        end
    endtask

    task automatic test_frac();
        int lat = 0;
        @(negedge clk);
        f2_a = 12'd2; f2_start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            f2_start = 1'b0;
            if (f2_done) begin lat = c; break; end
        end
        n_checks++; if (lat !== 9) begin n_fails++; $display("FAIL frac_latency got=%0d want=9", lat); end
        n_checks++; if (f2_q !== 8'd5 || f2_r !== 9'd7) begin
            n_fails++; $display("FAIL frac_2 Q=%0d R=%0d want Q=5 R=7", f2_q, f2_r);
        end
    endtask

    // Previous result is 63/126 from A=4095.
    task automatic test_busy_start();
        int lat = 0; int ndone = 0;
        @(negedge clk);
        a = 12'd1680; start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = (c == 2);
            a     = (c == 2) ? 12'd9 : 12'd1680;
            if (c == 4) begin
                n_checks++; if (q !== 6'd63 || r !== 7'd126) begin
                    n_fails++; $display("FAIL busy_hold Q=%0d R=%0d want Q=63 R=126", q, r);
                end
            end
            if (done) begin
                ndone++;
                if (lat == 0) lat = c;
            end
        end
        n_checks++; if (ndone !== 1) begin n_fails++; $display("FAIL busy_done_count got=%0d want=1", ndone); end
        n_checks++; if (lat !== 7) begin n_fails++; $display("FAIL busy_latency got=%0d want=7", lat); end
        n_checks++; if (q !== 6'd40 || r !== 7'd80) begin
            n_fails++; $display("FAIL busy_result Q=%0d R=%0d want Q=40 R=80", q, r);
        end
    endtask

    task automatic test_reset_mid();
        int ndone = 0; int lat; logic b1;
        @(negedge clk);
        a = 12'd4095; start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) ndone++;
            if (c == 3) rst_ = 1'b0;
            if (c == 4) begin
                rst_ = 1'b1;
                n_checks++; if (ready !== 1'b1 || busy !== 1'b0) begin
                    n_fails++; $display("FAIL rstmid_flags ready=%b busy=%b want 1 0", ready, busy);
                end
                n_checks++; if (q !== 6'd0 || r !== 7'd0) begin
                    n_fails++; $display("FAIL rstmid_outputs Q=%0d R=%0d want 0 0", q, r);
                end
            end
        end
        repeat (10) begin
            @(negedge clk);
            if (done) ndone++;
        end
        n_checks++; if (ndone !== 0) begin n_fails++; $display("FAIL rstmid_no_done got=%0d want=0", ndone); end
        run_op(12'd256, lat, b1);
        n_checks++; if (lat !== 7 || q !== 6'd16 || r !== 7'd0) begin
            n_fails++; $display("FAIL rstmid_restart lat=%0d Q=%0d R=%0d want 7 16 0", lat, q, r);
        end
    endtask

    task automatic test_back_to_back();
        int lat1 = 0; int lat2 = 0;
        @(negedge clk);
        a = 12'd256; start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (lat1 != 0 && c == lat1 + 3) begin
                n_checks++; if (q !== 6'd16 || busy !== 1'b1) begin
                    n_fails++; $display("FAIL b2b_hold Q=%0d busy=%b want Q=16 busy=1", q, busy);
                end
            end
            if (done) begin
                if (lat1 == 0) begin
                    lat1 = c;
                    n_checks++; if (q !== 6'd16 || r !== 7'd0) begin
                        n_fails++; $display("FAIL b2b_first Q=%0d R=%0d want Q=16 R=0", q, r);
                    end
                    a = 12'd1680;
                end else begin
                    lat2 = c;
                    start = 1'b0;
                    n_checks++; if (q !== 6'd40 || r !== 7'd80) begin
                        n_fails++; $display("FAIL b2b_second Q=%0d R=%0d want Q=40 R=80", q, r);
                    end
                    break;
                end
            end
        end
        start = 1'b0;
        n_checks++; if (lat2 - lat1 !== 8 || lat1 !== 7) begin
            n_fails++; $display("FAIL b2b_spacing first=%0d spacing=%0d want 7 8", lat1, lat2 - lat1);
        end
        repeat (3) @(negedge clk);
    endtask

    // Start held high on every sweep instance; first operand 0, then all-ones, then random.
    task automatic test_sweep();
        @(negedge clk);
        a = '0; s0_a = '0; s1_a = '0; s2_a = '0; s3_a = '0; s4_a = '0;
        start = 1'b1; sw_start = 1'b1;
        fork
            begin : b_main
                int ops = 0; int iss = 1; logic [11:0] acc = '0; longint unsigned x, eq;
                for (int c = 0; c < 30000 && ops < N_SWEEP; c++) begin
                    @(negedge clk);
                    if (done) begin
                        x = 64'(acc); eq = isqrt(x); ops++; n_checks++;
                        if (q !== 6'(eq) || r !== 7'(x - eq * eq)) begin
                            n_fails++; $display("FAIL sweep_w12f0 A=%0d Q=%0d R=%0d want Q=%0d R=%0d", acc, q, r, eq, x - eq * eq);
                        end
                    end
                    if (ready) begin a = (iss == 1) ? 12'hFFF : 12'($urandom); acc = a; iss++; end
                end
                if (ops < N_SWEEP) begin n_checks++; n_fails++; $display("FAIL sweep_w12f0_timeout ops=%0d want=%0d", ops, N_SWEEP); end
            end
            begin : b_s0
                int ops = 0; int iss = 1; logic [3:0] acc = '0; longint unsigned x, eq;
                for (int c = 0; c < 30000 && ops < N_SWEEP; c++) begin
                    @(negedge clk);
                    if (s0_done) begin
                        x = 64'(acc); eq = isqrt(x); ops++; n_checks++;
                        if (s0_q !== 2'(eq) || s0_r !== 3'(x - eq * eq)) begin
                            n_fails++; $display("FAIL sweep_w4f0 A=%0d Q=%0d R=%0d want Q=%0d R=%0d", acc, s0_q, s0_r, eq, x - eq * eq);
                        end
                    end
                    if (s0_ready) begin s0_a = (iss == 1) ? 4'hF : 4'($urandom); acc = s0_a; iss++; end
                end
                if (ops < N_SWEEP) begin n_checks++; n_fails++; $display("FAIL sweep_w4f0_timeout ops=%0d want=%0d", ops, N_SWEEP); end
            end
            begin : b_s1
                int ops = 0; int iss = 1; logic [3:0] acc = '0; longint unsigned x, eq;
                for (int c = 0; c < 30000 && ops < N_SWEEP; c++) begin
                    @(negedge clk);
                    if (s1_done) begin
                        x = 64'(acc) << 6; eq = isqrt(x); ops++; n_checks++;
                        if (s1_q !== 5'(eq) || s1_r !== 6'(x - eq * eq)) begin
                            n_fails++; $display("FAIL sweep_w4f3 A=%0d Q=%0d R=%0d want Q=%0d R=%0d", acc, s1_q, s1_r, eq, x - eq * eq);
                        end
                    end
                    if (s1_ready) begin s1_a = (iss == 1) ? 4'hF : 4'($urandom); acc = s1_a; iss++; end
                end
                if (ops < N_SWEEP) begin n_checks++; n_fails++; $display("FAIL sweep_w4f3_timeout ops=%0d want=%0d", ops, N_SWEEP); end
            end
            begin : b_s2
                int ops = 0; int iss = 1; logic [11:0] acc = '0; longint unsigned x, eq;
                for (int c = 0; c < 30000 && ops < N_SWEEP; c++) begin
                    @(negedge clk);
                    if (s2_done) begin
                        x = 64'(acc) << 6; eq = isqrt(x); ops++; n_checks++;
                        if (s2_q !== 9'(eq) || s2_r !== 10'(x - eq * eq)) begin
                            n_fails++; $display("FAIL sweep_w12f3 A=%0d Q=%0d R=%0d want Q=%0d R=%0d", acc, s2_q, s2_r, eq, x - eq * eq);
                        end
                    end
                    if (s2_ready) begin s2_a = (iss == 1) ? 12'hFFF : 12'($urandom); acc = s2_a; iss++; end
                end
                if (ops < N_SWEEP) begin n_checks++; n_fails++; $display("FAIL sweep_w12f3_timeout ops=%0d want=%0d", ops, N_SWEEP); end
            end
            begin : b_s3
                int ops = 0; int iss = 1; logic [15:0] acc = '0; longint unsigned x, eq;
                for (int c = 0; c < 30000 && ops < N_SWEEP; c++) begin
                    @(negedge clk);
                    if (s3_done) begin
                        x = 64'(acc); eq = isqrt(x); ops++; n_checks++;
                        if (s3_q !== 8'(eq) || s3_r !== 9'(x - eq * eq)) begin
                            n_fails++; $display("FAIL sweep_w16f0 A=%0d Q=%0d R=%0d want Q=%0d R=%0d", acc, s3_q, s3_r, eq, x - eq * eq);
                        end
                    end
                    if (s3_ready) begin s3_a = (iss == 1) ? 16'hFFFF : 16'($urandom); acc = s3_a; iss++; end
                end
                if (ops < N_SWEEP) begin n_checks++; n_fails++; $display("FAIL sweep_w16f0_timeout ops=%0d want=%0d", ops, N_SWEEP); end
            end
            begin : b_s4
                int ops = 0; int iss = 1; logic [15:0] acc = '0; longint unsigned x, eq;
                for (int c = 0; c < 30000 && ops < N_SWEEP; c++) begin
                    @(negedge clk);
                    if (s4_done) begin
                        x = 64'(acc) << 6; eq = isqrt(x); ops++; n_checks++;
                        if (s4_q !== 11'(eq) || s4_r !== 12'(x - eq * eq)) begin
                            n_fails++; $display("FAIL sweep_w16f3 A=%0d Q=%0d R=%0d want Q=%0d R=%0d", acc, s4_q, s4_r, eq, x - eq * eq);
                        end
                    end
                    if (s4_ready) begin s4_a = (iss == 1) ? 16'hFFFF : 16'($urandom); acc = s4_a; iss++; end
                end
                if (ops < N_SWEEP) begin n_checks++; n_fails++; $display("FAIL sweep_w16f3_timeout ops=%0d want=%0d", ops, N_SWEEP); end
            end
        join
        start = 1'b0; sw_start = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_values();
        test_frac();
        test_busy_start();
        test_reset_mid();
        test_back_to_back();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
